// File: rtl/hack_pkg.sv
// Shared Hack definitions: datapath width, ALU control word layout and the
// canonical ALU function encodings used by the CPU decoder and benches.
package hack_pkg;

  localparam int HACK_WIDTH = 16;

  // Field order matches the textual opcode order zx nx zy ny f no (zx = MSB).
  typedef struct packed {
    logic zx;
    logic nx;
    logic zy;
    logic ny;
    logic f;
    logic no;
  } alu_ctrl_t;

  localparam logic [5:0] OP_ZERO     = 6'b101010;
  localparam logic [5:0] OP_ONE      = 6'b111111;
  localparam logic [5:0] OP_NEG_ONE  = 6'b111010;
  localparam logic [5:0] OP_X        = 6'b001100;
  localparam logic [5:0] OP_Y        = 6'b110000;
  localparam logic [5:0] OP_NOT_X    = 6'b001101;
  localparam logic [5:0] OP_NOT_Y    = 6'b110001;
  localparam logic [5:0] OP_NEG_X    = 6'b001111;
  localparam logic [5:0] OP_NEG_Y    = 6'b110011;
  localparam logic [5:0] OP_X_INC    = 6'b011111;
  localparam logic [5:0] OP_Y_INC    = 6'b110111;
  localparam logic [5:0] OP_X_DEC    = 6'b001110;
  localparam logic [5:0] OP_Y_DEC    = 6'b110010;
  localparam logic [5:0] OP_X_ADD_Y  = 6'b000010;
  localparam logic [5:0] OP_X_SUB_Y  = 6'b010011;
  localparam logic [5:0] OP_Y_SUB_X  = 6'b000111;
  localparam logic [5:0] OP_X_AND_Y  = 6'b000000;
  localparam logic [5:0] OP_X_OR_Y   = 6'b010101;

endpackage

// File: rtl/alu_core.sv
// Combinational Hack ALU datapath: operand conditioning, add/and, output
// inversion, and the zero/negative flags.
module alu_core
  import hack_pkg::*;
#(
  parameter int WIDTH = HACK_WIDTH
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  alu_ctrl_t        ctrl,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng
);

  logic [WIDTH-1:0] x1, x2, y1, y2, r;

  always_comb begin
    x1 = ctrl.zx ? '0 : x;
    x2 = ctrl.nx ? ~x1 : x1;
    y1 = ctrl.zy ? '0 : y;
    y2 = ctrl.ny ? ~y1 : y1;
    // Sum is truncated to WIDTH bits; the carry-out is intentionally dropped.
    r   = ctrl.f ? (x2 + y2) : (x2 & y2);
    out = ctrl.no ? ~r : r;
    zr  = ~|out;
    ng  = out[WIDTH-1];
  end

endmodule

// File: rtl/hack_alu.sv
// Hack ALU top: combinational result and flags, plus an enable-loaded
// registered copy for pipelined/debug consumers.
module hack_alu
  import hack_pkg::*;
#(
  parameter int WIDTH = HACK_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             zx,
  input  logic             nx,
  input  logic             zy,
  input  logic             ny,
  input  logic             f,
  input  logic             no,
  input  logic             en,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng,
  output logic [WIDTH-1:0] out_q,
  output logic             zr_q,
  output logic             ng_q
);

  alu_ctrl_t        ctrl;
  logic [WIDTH-1:0] out_p1;
  logic             zr_p1;
  logic             ng_p1;

  assign ctrl = '{zx: zx, nx: nx, zy: zy, ny: ny, f: f, no: no};

  alu_core #(.WIDTH(WIDTH)) u_core (
    .x    (x),
    .y    (y),
    .ctrl (ctrl),
    .out  (out),
    .zr   (zr),
    .ng   (ng)
  );

  // Stage p0 -> p1: reset state mirrors a zero result (zr set, ng clear).
  always_ff @(posedge clk) begin
    if (reset) begin
      out_p1 <= '0;
      zr_p1  <= 1'b1;
      ng_p1  <= 1'b0;
    end else if (en) begin
      out_p1 <= out;
      zr_p1  <= zr;
      ng_p1  <= ng;
    end
  end

  assign out_q = out_p1;
  assign zr_q  = zr_p1;
  assign ng_q  = ng_p1;

endmodule

// File: tb/tb_hack_alu.sv
// Scoreboard bench for hack_alu: directed Hack functions, register path and
// a randomized sweep of all 64 control codes against a reference model.
module tb_hack_alu;
  import hack_pkg::*;

  localparam int W = HACK_WIDTH;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         en = 1'b0;
  logic         zx = 1'b0, nx = 1'b0, zy = 1'b0, ny = 1'b0, f = 1'b0, no = 1'b0;
  logic [W-1:0] x = '0, y = '0;
  logic [W-1:0] out, out_q;
  logic         zr, ng, zr_q, ng_q;

  always #5 clk = ~clk;

  hack_alu #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .x     (x),
    .y     (y),
    .zx    (zx),
    .nx    (nx),
    .zy    (zy),
    .ny    (ny),
    .f     (f),
    .no    (no),
    .en    (en),
    .out   (out),
    .zr    (zr),
    .ng    (ng),
    .out_q (out_q),
    .zr_q  (zr_q),
    .ng_q  (ng_q)
  );

  typedef struct packed {
    logic [W-1:0] o;
    logic         z;
    logic         n;
    int           due;
  } exp_t;

  exp_t   comb_q[$];
  exp_t   reg_q[$];
  string  comb_n[$];
  string  reg_n[$];
  int     total = 0;
  int     bad = 0;
  int     cyc = 0;

  logic [W-1:0] m_out = '0;
  logic         m_zr = 1'b1;
  logic         m_ng = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: operands are treated as integers; arithmetic done modulo 2^W.
  function automatic logic [W-1:0] ref_alu(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [5:0] op);
    longint unsigned mod, xa, yb, r;
    mod = longint'(1) << W;
    xa = op[5] ? 0 : longint'(a);
    if (op[4]) xa = (mod - 1) - xa;
    yb = op[3] ? 0 : longint'(b);
    if (op[2]) yb = (mod - 1) - yb;
    r = op[1] ? (xa + yb) % mod : (xa & yb);
    if (op[0]) r = (mod - 1) - r;
    return r[W-1:0];
  endfunction

  task automatic issue(input logic [W-1:0] xi, input logic [W-1:0] yi, input logic [5:0] op,
                       input logic e, input logic r, input logic [W-1:0] exp_o, input string nm);
    exp_t c;
    exp_t q;
    @(posedge clk);
    #1;
    x = xi; y = yi; en = e; reset = r;
    {zx, nx, zy, ny, f, no} = op;
    c.o = exp_o; c.z = (exp_o == '0); c.n = exp_o[W-1]; c.due = cyc;
    comb_q.push_back(c);
    comb_n.push_back(nm);
    if (r) begin
      m_out = '0; m_zr = 1'b1; m_ng = 1'b0;
    end else if (e) begin
      m_out = c.o; m_zr = c.z; m_ng = c.n;
    end
    q.o = m_out; q.z = m_zr; q.n = m_ng; q.due = cyc + 1;
    reg_q.push_back(q);
    reg_n.push_back({nm, "_q"});
  endtask

  task automatic check(input string nm, input logic [W-1:0] o, input logic z, input logic n,
                       input exp_t e);
    total++;
    if (o !== e.o || z !== e.z || n !== e.n) begin
      bad++;
      $display("FAIL %s: got out=%h zr=%b ng=%b, expected out=%h zr=%b ng=%b",
               nm, o, z, n, e.o, e.z, e.n);
    end
  endtask

  // Monitor: compares DUT outputs on the falling edge, independent of the driver.
  exp_t  mon_e;
  string mon_n;
  always @(negedge clk) begin
    if (comb_q.size() > 0 && comb_q[0].due <= cyc) begin
      mon_e = comb_q.pop_front();
      mon_n = comb_n.pop_front();
      check(mon_n, out, zr, ng, mon_e);
    end
    if (reg_q.size() > 0 && reg_q[0].due <= cyc) begin
      mon_e = reg_q.pop_front();
      mon_n = reg_n.pop_front();
      check(mon_n, out_q, zr_q, ng_q, mon_e);
    end
  end

  initial begin
    logic [W-1:0] rx, ry;
    logic         re, rr;
    int           wait_cyc;

    // Register path: reset, load, hold, reset beats enable.
    issue(16'h0011, 16'h0003, OP_X_ADD_Y, 1'b0, 1'b1, 16'h0014, "reset");
    issue(16'h0011, 16'h0003, OP_X_ADD_Y, 1'b1, 1'b0, 16'h0014, "load_add");
    issue(16'h0011, 16'h0003, OP_X_SUB_Y, 1'b0, 1'b0, 16'h000E, "hold_sub");
    issue(16'h0011, 16'h0003, OP_X_OR_Y,  1'b0, 1'b0, 16'h0013, "hold_or");
    issue(16'h0011, 16'h0003, OP_X_INC,   1'b1, 1'b1, 16'h0012, "reset_en");

    // Constants
    issue(16'h0000, 16'hFFFF, OP_ZERO,    1'b1, 1'b0, 16'h0000, "zero");
    issue(16'h0000, 16'hFFFF, OP_ONE,     1'b1, 1'b0, 16'h0001, "one");
    issue(16'h0000, 16'hFFFF, OP_NEG_ONE, 1'b1, 1'b0, 16'hFFFF, "neg_one");
    // Arithmetic
    issue(16'h0011, 16'h0003, OP_X_ADD_Y, 1'b1, 1'b0, 16'h0014, "x_add_y");
    issue(16'h0011, 16'h0003, OP_X_SUB_Y, 1'b1, 1'b0, 16'h000E, "x_sub_y");
    issue(16'h0011, 16'h0003, OP_Y_SUB_X, 1'b1, 1'b0, 16'hFFF2, "y_sub_x");
    issue(16'h0011, 16'h0003, OP_X_INC,   1'b1, 1'b0, 16'h0012, "x_inc");
    issue(16'h0011, 16'h0003, OP_Y_DEC,   1'b1, 1'b0, 16'h0002, "y_dec");
    // Logic and negation
    issue(16'h0011, 16'h0003, OP_X_AND_Y, 1'b1, 1'b0, 16'h0001, "x_and_y");
    issue(16'h0011, 16'h0003, OP_X_OR_Y,  1'b1, 1'b0, 16'h0013, "x_or_y");
    issue(16'h0011, 16'h0003, OP_NOT_X,   1'b1, 1'b0, 16'hFFEE, "not_x");
    issue(16'h0011, 16'h0003, OP_NEG_X,   1'b1, 1'b0, 16'hFFEF, "neg_x");
    issue(16'h0011, 16'h0003, OP_NEG_Y,   1'b1, 1'b0, 16'hFFFD, "neg_y");
    issue(16'h0011, 16'h0003, OP_X,       1'b1, 1'b0, 16'h0011, "pass_x");
    issue(16'h0011, 16'h0003, OP_Y,       1'b1, 1'b0, 16'h0003, "pass_y");
    issue(16'h0011, 16'h0003, OP_NOT_Y,   1'b1, 1'b0, 16'hFFFC, "not_y");
    // Wrap-around and zero flag
    issue(16'h0000, 16'hFFFF, OP_X_ADD_Y, 1'b1, 1'b0, 16'hFFFF, "wrap_add");
    issue(16'h0000, 16'hFFFF, OP_Y_INC,   1'b1, 1'b0, 16'h0000, "wrap_y_inc");
    issue(16'h0000, 16'hFFFF, OP_X_DEC,   1'b1, 1'b0, 16'hFFFF, "wrap_x_dec");
    issue(16'hFFFF, 16'h0001, OP_X_ADD_Y, 1'b1, 1'b0, 16'h0000, "carry_drop");

    // All 64 control codes with random operands, enables and occasional resets.
    for (int op = 0; op < 64; op++) begin
      for (int k = 0; k < 3; k++) begin
        rx = W'($urandom);
        ry = W'($urandom);
        re = 1'($urandom_range(0, 1));
        rr = ($urandom_range(0, 15) == 0);
        issue(rx, ry, 6'(op), re, rr, ref_alu(rx, ry, 6'(op)), $sformatf("sweep_op%0d", op));
      end
    end

    @(posedge clk);
    #1;
    en = 1'b0;
    reset = 1'b0;
    wait_cyc = 0;
    while ((comb_q.size() > 0 || reg_q.size() > 0) && wait_cyc < 10) begin
      @(posedge clk);
      wait_cyc++;
    end
    if (comb_q.size() > 0 || reg_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending entries, expected 0", comb_q.size() + reg_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hack_alu.md
# hack_alu

Hack-platform 16-bit arithmetic/logic unit, instantiated as module `alu` inside the CPU datapath. It computes one of the Hack ALU functions on operands `x` and `y`, selected by six control bits. It drives a combinational result with zero and negative flags in the same cycle. It also keeps a registered copy of result and flags for pipelined or debug consumers.

## Interface
- `WIDTH`, default 16: operand/result width. The CPU uses 16.
- `clk`  in  1: system clock; the only clock.
- `reset`  in  1: synchronous, active-high reset; affects registered outputs only.
- `x`  in  WIDTH: first operand (D register in CPU).
- `y`  in  WIDTH: second operand (A register or M).
- `zx`  in  1: force x to 0.
- `nx`  in  1: bitwise-invert x, applied after zx.
- `zy`  in  1: force y to 0.
- `ny`  in  1: bitwise-invert y, applied after zy.
- `f`  in  1: function select; 1 = add, 0 = bitwise AND.
- `no`  in  1: bitwise-invert the function result.
- `en`  in  1: load enable for registered outputs.
- `out`  out  WIDTH: combinational result.
- `zr`  out  1: combinational; 1 iff `out` == 0.
- `ng`  out  1: combinational; equals `out[WIDTH-1]`.
- `out_q`  out  WIDTH: registered `out`.
- `zr_q`  out  1: registered `zr`.
- `ng_q`  out  1: registered `ng`.

## Operation
- The combinational path is evaluated in this fixed order:
  - x1 = zx ? 0 : x
  - x2 = nx ? ~x1 : x1
  - y1 = zy ? 0 : y
  - y2 = ny ? ~y1 : y1
  - r = f ? (x2 + y2) mod 2^WIDTH : (x2 & y2)
  - out = no ? ~r : r
- Addition wraps: the carry-out is discarded and there is no overflow flag.
- `zr` is the NOR of all `out` bits. `ng` is the MSB of `out` (two's-complement sign).
- All 64 control combinations are legal and produce exactly the function above; there is no illegal opcode.
- Canonical Hack results (zx nx zy ny f no):
  - 101010 = 0; 111111 = 1; 111010 = -1
  - 001100 = x; 110000 = y; 001101 = !x; 110001 = !y
  - 001111 = -x; 110011 = -y; 011111 = x+1; 110111 = y+1
  - 001110 = x-1; 110010 = y-1; 000010 = x+y
  - 010011 = x-y; 000111 = y-x; 000000 = x&y; 010101 = x|y
- Registered path: on a rising `clk` edge:
  - `reset`=1: `out_q`=0, `zr_q`=1, `ng_q`=0.
  - otherwise `en`=1: `out_q`/`zr_q`/`ng_q` load the current `out`/`zr`/`ng`.
  - otherwise: hold.
- `reset` has priority over `en`.

## Timing
- `out`, `zr`, `ng`: zero-cycle latency, purely combinational from `x`, `y` and the control bits; no dependence on `clk` or `reset`.
- `out_q`, `zr_q`, `ng_q`: one-cycle latency, valid after the edge at which `en`=1 was sampled.
- Reset asserted mid-operation: registered outputs are cleared at that edge, and the combinational outputs are unaffected.
- There is no handshake and no state machine. Inputs may change every cycle.

## Structure
- A shared `hack_pkg` holds:
  - `HACK_WIDTH` = 16.
  - A packed `alu_ctrl_t` struct {zx, nx, zy, ny, f, no}.
  - Named 6-bit constants for the 18 canonical functions listed above, for use by the CPU decoder and by benches.
- One combinational sub-module, `alu_core`, implements the Operation datapath and flags. The top level adds only the output register.

## Test plan
- Constants, with x=0x0000, y=0xFFFF:
  - 101010 -> out=0x0000, zr=1, ng=0
  - 111111 -> 0x0001, zr=0, ng=0
  - 111010 -> 0xFFFF, ng=1
- Arithmetic, with x=0x0011, y=0x0003:
  - 000010 -> 0x0014
  - 010011 -> 0x000E
  - 000111 -> 0xFFF2, ng=1
  - 011111 -> 0x0012
  - 110010 -> 0x0002
- Logic and negation, with x=0x0011, y=0x0003:
  - 000000 -> 0x0001
  - 010101 -> 0x0013
  - 001101 -> 0xFFEE, ng=1
  - 001111 -> 0xFFEF
  - 110011 -> 0xFFFD
- Wrap-around and zero flag, with x=0x0000, y=0xFFFF:
  - 000010 -> 0xFFFF, ng=1
  - 110111 (y+1) -> 0x0000, zr=1
  - 001110 (x-1) -> 0xFFFF
- Register path:
  - Reset for 1 cycle -> out_q=0, zr_q=1, ng_q=0.
  - en=1 with x=0x0011, y=0x0003, op 000010 -> out_q=0x0014 on the next edge.
  - en=0 with a new op -> out_q holds 0x0014.
  - reset and en asserted together -> cleared.
- Exhaustive control sweep: all 64 control codes × random operands, compared against a reference model of the Operation equations, including zr/ng consistency with `out`.
